// File: rtl/cia_serial_pkg.sv
// Shared types and constants for the CIA serial data port.
package cia;

   typedef logic [3:0] reg4_t;
   typedef logic [7:0] reg8_t;

   // Serial port sequencer states.
   typedef enum logic [0:0] {
      SP_IDLE  = 1'b0,
      SP_SHIFT = 1'b1
   } sp_state_t;

   // Register address of the serial data register.
   localparam reg4_t SDR_ADDR = 4'hC;

   // Half-bit counter value at the last underflow of an output byte (16th).
   localparam logic [3:0] HCNT_LAST_OUT = 4'd15;

   // Half-bit counter value just before the 8th input edge (counts by two).
   localparam logic [3:0] HCNT_LAST_IN = 4'd14;

endpackage

// File: rtl/cia_serial.sv
// CIA serial data port (SDR). Output mode shifts the SDR out MSB-first on SP,
// with CNT toggled once per timer A underflow (two underflows per bit).
// Input mode samples SP on each rising CNT edge. A completed byte raises the
// SP interrupt source for exactly one phi2 cycle.
//
// Bus/pin strobe semantics: every register and pin sample below is taken only
// on a clk edge where phi2_dn is high; between strobes all state holds. There
// is no backpressure: a write strobe is always accepted in the cycle it occurs.
module cia_serial
   import cia::*;
(
   input  logic      clk,
   input  logic      res,
   input  logic      phi2_dn,
   input  logic      rd,
   input  logic      we,
   input  reg4_t     addr,
   input  reg8_t     data,
   input  logic      sp_out_mode,
   input  logic      ta_underflow,
   input  logic      cnt_in,
   input  logic      sp_in,
   output reg8_t     regs,
   output logic      sp_out,
   output logic      sp_oe,
   output logic      cnt_out,
   output logic      cnt_oe,
   output logic      irq_sp,
   output sp_state_t dbg_state
);

   // Registered state
   reg8_t     r_sdr;
   reg8_t     r_shifter;
   logic [3:0] r_hcnt;
   logic      r_pending;
   sp_state_t r_state;
   logic      r_cnt_out;
   logic      r_sp_out;
   logic      r_irq_sp;
   logic      r_cnt_prev;
   logic      r_mode_prev;

   // Decoded strobes
   logic      w_sdr_wr;
   logic      w_mode_chg;
   logic      w_cnt_rise;
   reg8_t     w_sdr_next;
   reg8_t     w_in_word;
   logic      w_pend_eff;
   logic      w_out_load;
   logic      w_out_step;
   logic      w_out_done;
   logic      w_in_edge;
   logic      w_in_done;
   logic      w_complete;

   // Reads are side-effect free and shifter bit 7 is never observed directly.
   logic [1:0] w_unused;
   assign w_unused = {rd, r_shifter[7]};

   assign w_sdr_wr   = phi2_dn && we && (addr == SDR_ADDR);
   assign w_mode_chg = (sp_out_mode != r_mode_prev);
   assign w_cnt_rise = cnt_in && !r_cnt_prev;

   // Value the SDR holds after this strobe if only the bus acts on it; a
   // reload in the same cycle as a write picks up the new byte.
   assign w_sdr_next = w_sdr_wr ? data : r_sdr;
   assign w_in_word  = {r_shifter[6:0], sp_in};

   // A write in the completing cycle counts as pending for back-to-back.
   assign w_pend_eff = r_pending || (w_sdr_wr && sp_out_mode);

   assign w_out_load = phi2_dn && sp_out_mode && !w_mode_chg &&
                       (r_state == SP_IDLE) && r_pending && ta_underflow;
   assign w_out_step = phi2_dn && sp_out_mode && !w_mode_chg &&
                       (r_state == SP_SHIFT) && ta_underflow;
   assign w_out_done = w_out_step && (r_hcnt == HCNT_LAST_OUT);
   assign w_in_edge  = phi2_dn && !sp_out_mode && !w_mode_chg && w_cnt_rise;
   assign w_in_done  = w_in_edge && (r_hcnt == HCNT_LAST_IN);
   assign w_complete = w_out_done || w_in_done;

   // SDR register: a finished input byte beats a bus write in the same cycle.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_sdr <= '0;
      end else if (phi2_dn) begin
         if (w_in_done) begin
            r_sdr <= w_in_word;
         end else if (w_sdr_wr) begin
            r_sdr <= data;
         end
      end
   end

   // Pending flag: an output-mode write waiting to be shifted out.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_pending <= 1'b0;
      end else if (phi2_dn) begin
         if (w_mode_chg || !sp_out_mode) begin
            r_pending <= 1'b0;
         end else if (w_out_load || (w_out_done && w_pend_eff)) begin
            r_pending <= 1'b0;
         end else if (w_sdr_wr) begin
            r_pending <= 1'b1;
         end
      end
   end

   // Sequencer, shifter, half-bit counter and CNT/SP pin drive.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state   <= SP_IDLE;
         r_shifter <= '0;
         r_hcnt    <= '0;
         r_cnt_out <= 1'b1;
         r_sp_out  <= 1'b1;
      end else if (phi2_dn) begin
         if (w_mode_chg) begin
            // Abort whatever was in flight; the SDR itself is kept.
            r_state   <= SP_IDLE;
            r_hcnt    <= '0;
            r_cnt_out <= 1'b1;
            r_sp_out  <= 1'b1;
         end else if (!sp_out_mode) begin
            // Input mode: pins are released high, CNT edges drive the shifter.
            r_state   <= SP_IDLE;
            r_cnt_out <= 1'b1;
            r_sp_out  <= 1'b1;
            if (w_in_edge) begin
               r_shifter <= w_in_word;
               r_hcnt    <= w_in_done ? 4'd0 : (r_hcnt + 4'd2);
            end
         end else begin
            case (r_state)
               SP_IDLE: begin
                  r_cnt_out <= 1'b1;
                  if (w_out_load) begin
                     // MSB is presented on SP as soon as the byte is loaded.
                     r_shifter <= w_sdr_next;
                     r_sp_out  <= w_sdr_next[7];
                     r_hcnt    <= '0;
                     r_state   <= SP_SHIFT;
                  end
               end
               SP_SHIFT: begin
                  if (w_out_step) begin
                     if (w_out_done) begin
                        r_cnt_out <= 1'b1;
                        r_hcnt    <= '0;
                        if (w_pend_eff) begin
                           r_shifter <= w_sdr_next;
                           r_sp_out  <= w_sdr_next[7];
                        end else begin
                           r_state <= SP_IDLE;
                        end
                     end else begin
                        r_cnt_out <= ~r_cnt_out;
                        r_hcnt    <= r_hcnt + 4'd1;
                        // Advance to the next bit on CNT falling, except the
                        // first fall, whose bit was already shown at load.
                        if (r_cnt_out && (r_hcnt != 4'd0)) begin
                           r_shifter <= {r_shifter[6:0], 1'b0};
                           r_sp_out  <= r_shifter[6];
                        end
                     end
                  end
               end
               default: begin
                  r_state <= SP_IDLE;
               end
            endcase
         end
      end
   end

   // Interrupt source: one full phi2 cycle of level after each finished byte.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_irq_sp <= 1'b0;
      end else if (phi2_dn) begin
         r_irq_sp <= w_complete;
      end
   end

   // Pin and mode history used for CNT edge detection and mode-change abort.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_cnt_prev  <= 1'b1;
         r_mode_prev <= 1'b0;
      end else if (phi2_dn) begin
         r_cnt_prev  <= cnt_in;
         r_mode_prev <= sp_out_mode;
      end
   end

   assign regs      = r_sdr;
   assign sp_out    = r_sp_out;
   assign cnt_out   = r_cnt_out;
   assign irq_sp    = r_irq_sp;
   assign sp_oe     = sp_out_mode;
   assign cnt_oe    = sp_out_mode;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_cia_serial.sv
// Bench for cia_serial: directed phi2-strobed stimulus, a byte-level model of
// the serial port checked every clock, plus hand-computed literal checks.
module tb_cia_serial;
  import cia::*;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      res = 1'b1;
  logic      phi2_dn = 1'b0;
  logic      rd = 1'b0;
  logic      we = 1'b0;
  reg4_t     addr = '0;
  reg8_t     data = '0;
  logic      sp_out_mode = 1'b0;
  logic      ta_underflow = 1'b0;
  logic      cnt_in = 1'b1;
  logic      sp_in = 1'b1;
  reg8_t     regs;
  logic      sp_out, sp_oe, cnt_out, cnt_oe, irq_sp;
  sp_state_t dbg_state;

  always #5 clk = ~clk;

  cia_serial dut (
    .clk(clk), .res(res), .phi2_dn(phi2_dn), .rd(rd), .we(we), .addr(addr),
    .data(data), .sp_out_mode(sp_out_mode), .ta_underflow(ta_underflow),
    .cnt_in(cnt_in), .sp_in(sp_in), .regs(regs), .sp_out(sp_out),
    .sp_oe(sp_oe), .cnt_out(cnt_out), .cnt_oe(cnt_oe), .irq_sp(irq_sp),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- byte-level model ----------------
  logic [7:0] m_sdr, m_byte;
  logic       m_pend, m_active, m_cnt, m_sp, m_irq, m_cnt_prev, m_mode_prev;
  int         m_k;          // underflows seen in the current output byte
  logic       m_bits[$];    // input bits collected so far

  task automatic model_reset();
    m_sdr = 8'h00; m_byte = 8'h00; m_pend = 1'b0; m_active = 1'b0;
    m_cnt = 1'b1; m_sp = 1'b1; m_irq = 1'b0; m_cnt_prev = 1'b1;
    m_mode_prev = 1'b0; m_k = 0; m_bits.delete();
  endtask

  task automatic model_step(input logic wr, input logic [7:0] d, input logic ufl,
                            input logic mode, input logic cin, input logic spin);
    logic       fire, pb;
    logic [7:0] w;
    int         idx;
    fire = 1'b0;
    if (mode != m_mode_prev) begin
      if (wr) m_sdr = d;
      m_pend = 1'b0; m_active = 1'b0; m_k = 0; m_bits.delete();
      m_cnt = 1'b1; m_sp = 1'b1;
    end else if (mode) begin
      pb = m_pend;
      if (wr) begin m_sdr = d; m_pend = 1'b1; end
      if (!m_active) begin
        if (pb && ufl) begin
          m_active = 1'b1; m_k = 0; m_byte = m_sdr; m_pend = 1'b0;
        end
      end else if (ufl) begin
        m_k++;
        if (m_k == 16) begin
          fire = 1'b1; m_k = 0;
          if (m_pend) begin m_byte = m_sdr; m_pend = 1'b0; end
          else m_active = 1'b0;
        end
      end
      if (m_active) begin
        // CNT low on odd half-bits; bit index advances every two underflows
        m_cnt = (m_k % 2 == 0);
        idx = (m_k == 0) ? 7 : 7 - (m_k - 1) / 2;
        m_sp = m_byte[idx];
      end else begin
        m_cnt = 1'b1;
      end
    end else begin
      m_cnt = 1'b1; m_sp = 1'b1;
      if (cin && !m_cnt_prev) begin
        m_bits.push_back(spin);
        if (m_bits.size() == 8) begin
          w = 8'h00;
          foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
          m_sdr = w; m_bits.delete(); fire = 1'b1;
        end
      end
      if (wr && !fire) m_sdr = d;
    end
    m_cnt_prev = cin; m_mode_prev = mode; m_irq = fire;
  endtask

  // ---------------- compare process (every clock) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("regs",    32'(regs),      32'(m_sdr));
      check("sp_out",  32'(sp_out),    32'(m_sp));
      check("cnt_out", 32'(cnt_out),   32'(m_cnt));
      check("irq_sp",  32'(irq_sp),    32'(m_irq));
      check("sp_oe",   32'(sp_oe),     32'(sp_out_mode));
      check("cnt_oe",  32'(cnt_oe),    32'(sp_out_mode));
      check("state",   32'(dbg_state), 32'(m_active ? SP_SHIFT : SP_IDLE));
    end
  end

  // ---------------- pin monitors ----------------
  int   n_tog = 0;
  int   n_irq = 0;
  logic rise_q[$];
  logic mon_cnt_prev = 1'b1;
  logic mon_irq_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (cnt_out && !mon_cnt_prev) rise_q.push_back(sp_out);
      if (cnt_out != mon_cnt_prev) n_tog++;
      if (irq_sp && !mon_irq_prev) n_irq++;
    end
    mon_cnt_prev = cnt_out;
    mon_irq_prev = irq_sp;
  end

  // ---------------- driver tasks ----------------
  // One phi2 cycle: four clocks, strobe on the first.
  task automatic tick(input logic t_we, input logic [7:0] t_data, input logic t_ufl,
                      input logic t_cnt, input logic t_sp);
    we = t_we; addr = t_we ? SDR_ADDR : 4'h0; data = t_data;
    ta_underflow = t_ufl; cnt_in = t_cnt; sp_in = t_sp; phi2_dn = 1'b1;
    @(posedge clk); #1;
    model_step(t_we, t_data, t_ufl, sp_out_mode, t_cnt, t_sp);
    phi2_dn = 1'b0; we = 1'b0; ta_underflow = 1'b0; rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rd = 1'b1;
      tick(1'b0, 8'h00, 1'b0, cnt_in, sp_in);
    end
  endtask

  task automatic ufl(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, cnt_in, sp_in);
  endtask

  task automatic wr_sdr(input logic [7:0] d);
    tick(1'b1, d, 1'b0, cnt_in, sp_in);
  endtask

  // CNT low then high; the low half also carries an underflow to show it is ignored.
  task automatic in_edge(input logic b, input logic t_we, input logic [7:0] t_data);
    tick(1'b0, 8'h00, 1'b1, 1'b0, b);
    tick(t_we, t_data, 1'b0, 1'b1, b);
  endtask

  // ---------------- directed sequence ----------------
  int         t0, i0, r0;
  logic [7:0] pat;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_regs", 32'(regs), 32'h00);
    check("rst_cnt",  32'(cnt_out), 32'h1);
    check("rst_sp",   32'(sp_out), 32'h1);
    check("rst_irq",  32'(irq_sp), 32'h0);
    res = 1'b0;
    chk_en = 1'b1;

    // Output mode, single byte A5
    sp_out_mode = 1'b1;
    idle(2);
    t0 = n_tog; i0 = n_irq; r0 = rise_q.size();
    wr_sdr(8'hA5);
    idle(1);
    ufl(17);      // one load underflow, then sixteen half-bits
    idle(2);
    pat = 8'hA5;
    check("a5_toggles", 32'(n_tog - t0), 32'd16);
    check("a5_irqs",    32'(n_irq - i0), 32'd1);
    check("a5_rises",   32'(rise_q.size() - r0), 32'd8);
    for (int i = 0; i < 8; i++)
      if (rise_q.size() > r0 + i) check("a5_bit", 32'(rise_q[r0 + i]), 32'(pat[7 - i]));
    check("a5_state", 32'(dbg_state), 32'(SP_IDLE));
    check("a5_cnt",   32'(cnt_out), 32'h1);
    check("a5_regs",  32'(regs), 32'hA5);

    // Back-to-back FF then 00
    t0 = n_tog; i0 = n_irq;
    wr_sdr(8'hFF);
    ufl(1);
    ufl(5);
    wr_sdr(8'h00);
    ufl(11);
    check("b2b_irq1",   32'(n_irq - i0), 32'd1);
    check("b2b_irq_hi", 32'(irq_sp), 32'h1);
    check("b2b_nogap",  32'(dbg_state), 32'(SP_SHIFT));
    check("b2b_msb0",   32'(sp_out), 32'h0);
    ufl(16);
    idle(2);
    check("b2b_irq2",   32'(n_irq - i0), 32'd2);
    check("b2b_tog",    32'(n_tog - t0), 32'd32);
    check("b2b_state",  32'(dbg_state), 32'(SP_IDLE));

    // Reset in the middle of a transfer
    wr_sdr(8'h5A);
    ufl(6);
    #2;
    res = 1'b1;
    chk_en = 1'b0;
    #1;
    check("mrst_cnt",  32'(cnt_out), 32'h1);
    check("mrst_sp",   32'(sp_out), 32'h1);
    check("mrst_irq",  32'(irq_sp), 32'h0);
    check("mrst_regs", 32'(regs), 32'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    chk_en = 1'b1;
    i0 = n_irq;
    ufl(3);
    check("mrst_idle",  32'(dbg_state), 32'(SP_IDLE));
    check("mrst_cnt2",  32'(cnt_out), 32'h1);
    check("mrst_noirq", 32'(n_irq - i0), 32'd0);

    // Input mode: 8 edges -> CA
    sp_out_mode = 1'b0;
    idle(1);
    i0 = n_irq;
    pat = 8'hCA;
    for (int i = 0; i < 8; i++) in_edge(pat[7 - i], 1'b0, 8'h00);
    idle(2);
    check("in_regs", 32'(regs), 32'hCA);
    check("in_irq",  32'(n_irq - i0), 32'd1);

    // Only 7 edges: nothing completes
    i0 = n_irq;
    pat = 8'h5E;
    for (int i = 0; i < 7; i++) in_edge(pat[7 - i], 1'b0, 8'h00);
    idle(2);
    check("in7_regs", 32'(regs), 32'hCA);
    check("in7_irq",  32'(n_irq - i0), 32'd0);

    // Bounce the mode to abort the partial byte
    sp_out_mode = 1'b1;
    idle(1);
    sp_out_mode = 1'b0;
    idle(1);

    // 8th edge coincides with a bus write of 11: shifted 3C wins
    i0 = n_irq;
    pat = 8'h3C;
    for (int i = 0; i < 7; i++) in_edge(pat[7 - i], 1'b0, 8'h00);
    in_edge(pat[0], 1'b1, 8'h11);
    check("sim_irq_hi", 32'(irq_sp), 32'h1);
    idle(2);
    check("sim_regs", 32'(regs), 32'h3C);
    check("sim_irq",  32'(n_irq - i0), 32'd1);

    // Output -> input switch after 6 underflows
    sp_out_mode = 1'b1;
    idle(1);
    wr_sdr(8'h77);
    ufl(7);
    i0 = n_irq;
    sp_out_mode = 1'b0;
    idle(1);
    check("sw_cnt",   32'(cnt_out), 32'h1);
    check("sw_sp",    32'(sp_out), 32'h1);
    check("sw_state", 32'(dbg_state), 32'(SP_IDLE));
    ufl(4);
    check("sw_regs",  32'(regs), 32'h77);
    sp_out_mode = 1'b1;
    idle(1);
    ufl(3);
    check("sw_nopend", 32'(dbg_state), 32'(SP_IDLE));
    check("sw_irq",    32'(n_irq - i0), 32'd0);
    idle(1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cia_serial.md
Name: cia_serial

Overview:
- Serial data port controller (SDR, register 'hC) with 8-bit shift engine and CNT/SP pin sequencing.
- Generates the SP interrupt source (sources[3]) for the interrupt block.
- Timer A underflow acts as the bit-rate scheduler in output mode; the external CNT clock is used in input mode.
- Sits beside the timers; its output feeds the interrupt flag/mask logic.

Parameters:
- None. Register address 'hC and all widths come from package cia.

Ports:
- clk  in  1  system clock
- res  in  1  reset; asynchronous, active-high
- phi2_dn  in  1  one-clk strobe at each phi2 falling edge; all bus and pin sampling is qualified by it
- rd  in  1  bus read
- we  in  1  bus write
- addr  in  cia::reg4_t  register address
- data  in  cia::reg8_t  write data
- sp_out_mode  in  1  CRA bit 6; 1 = output mode, 0 = input mode
- ta_underflow  in  1  timer A underflow, valid when phi2_dn=1
- cnt_in  in  1  synchronized CNT pin
- sp_in  in  1  synchronized SP pin
- regs  out  cia::reg8_t  SDR read value
- sp_out  out  1  SP pin drive value
- sp_oe  out  1  SP output enable
- cnt_out  out  1  CNT pin drive value
- cnt_oe  out  1  CNT output enable
- irq_sp  out  1  SP interrupt source

Behaviour:
- Reset (asynchronous):
  - sdr, shifter and half-bit counter hcnt[3:0] = 0; pending = 0; state = SP_IDLE.
  - cnt_out = 1, sp_out = 1, irq_sp = 0, cnt_prev = 1.
  - sp_oe and cnt_oe stay combinational from sp_out_mode.
- Outputs:
  - sp_oe = cnt_oe = sp_out_mode.
  - regs = sdr at all times; reads have no side effects.
- State update: all state changes occur on clk edges with phi2_dn=1, except irq_sp timing below.
- Write (we && addr=='hC && phi2_dn): sdr <= data; in output mode pending <= 1.
- Output mode, SP_IDLE:
  - If pending && ta_underflow: shifter <= sdr, pending <= 0, hcnt <= 0, state <= SP_SHIFT, sp_out <= sdr[7].
  - cnt_out stays 1.
- Output mode, SP_SHIFT, on each ta_underflow:
  - cnt_out <= ~cnt_out; hcnt <= hcnt+1.
  - On 1->0 of cnt_out with hcnt != 0: shifter <= shifter<<1 and sp_out <= shifter[6]. The MSB is already presented at load.
  - Completion is the underflow where hcnt==15, i.e. the 16th underflow; cnt_out returns to 1 there. Then irq_sp is raised.
    - If pending (including a write in that same cycle): reload shifter from sdr, pending <= 0, sp_out <= sdr[7], hcnt <= 0, stay SP_SHIFT (back-to-back, no gap).
    - Else: state <= SP_IDLE.
- Input mode:
  - cnt_prev <= cnt_in each phi2_dn.
  - A rising edge is cnt_in && !cnt_prev. On it: shifter <= {shifter[6:0], sp_in}; hcnt <= hcnt+2.
  - On the 8th edge: sdr <= {shifter[6:0], sp_in}, hcnt <= 0, irq_sp raised.
  - A bus write in the same cycle as the 8th edge loses: the shifted value wins.
  - state stays SP_IDLE; cnt_out = 1, sp_out = 1.
- irq_sp timing: asserted on the clk after the completing phi2_dn, held until the next phi2_dn.
  - Exactly one phi2 cycle of level, so the interrupt block's MOS6526 and MOS8521 sampling both see it.
- Mode change (sp_out_mode differs from its value at the previous phi2_dn):
  - Aborts any transfer: state <= SP_IDLE, hcnt <= 0, pending <= 0, cnt_out <= 1, sp_out <= 1, no irq_sp.
  - sdr is preserved.
- Timing boundaries:
  - ta_underflow in output mode with nothing pending: no effect.
  - ta_underflow in input mode: ignored.
- Counter width: hcnt wraps only via explicit clear; it never exceeds 15.

Decomposition:
- Package cia:
  - sp_state_t enum {SP_IDLE, SP_SHIFT}
  - localparam SDR_ADDR = 4'hC
- Single module; no natural sub-module. Edge detect and shifter stay inline.

Test Plan:
- Reset mid-transfer (output mode, after 5 underflows) -> immediately cnt_out=1, sp_out=1, irq_sp=0, regs=0; a later underflow with no write does nothing.
- Output mode: write 'hA5, then 16 ta_underflow pulses -> sp_out sequence on cnt_out rising edges 1,0,1,0,0,1,0,1.
  - cnt_out toggles 16 times, ending at 1.
  - irq_sp high for exactly one phi2 cycle after the 16th underflow.
  - State returns to SP_IDLE.
- Back-to-back: write 'hFF, then write 'h00 during the transfer -> at the 16th underflow irq_sp pulses and the 'h00 transfer starts with no idle underflow.
  - A second irq_sp pulse follows after 16 more underflows.
- Input mode: 8 rising cnt_in edges with sp_in = 1,1,0,0,1,0,1,0 -> regs='hCA and one irq_sp pulse.
  - Only 7 edges -> regs unchanged, no irq_sp.
- Simultaneous: in input mode, bus write 'h11 in the same cycle as the 8th edge (data 'h3C) -> regs='h3C, irq_sp pulses.
- Mode switch output->input after 6 underflows -> no irq_sp, cnt_out=1, pending cleared.
  - Subsequent ta_underflow pulses ignored; sdr retains the last written value.
